plot_framebuffer_scan: RTL and testbench

PLOT_FRAMEBUFFER_SCAN -- requirements
Module: plot_framebuffer_scan

---
 rtl/plot_fb_pkg.sv | 42 ++++
 rtl/plot_framebuffer_scan_if.sv | 14 +
 rtl/plot_fb_ram.sv | 32 +++
 rtl/plot_framebuffer_scan.sv | 157 +++++++++++++++
 tb/tb_plot_framebuffer_scan.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/plot_fb_pkg.sv
// Shared types and constants for the plot framebuffer and its raster scanner.
// Screen geometry defaults, colour type, address width and scan phase decoding.
package plot_fb_pkg;

  typedef logic [2:0] colour_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ADDR_W   = 15;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic frameStart;
  } syncBits_t;

  // Idle video timing: syncs deasserted (high), blanked, no frame pulse.
  localparam syncBits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1, frameStart: 1'b0};

  function automatic phase_t phaseOf(input int pos, input int active, input int fp, input int sync);
    if (pos < active) begin
      return PH_ACTIVE;
    end else if (pos < active + fp) begin
      return PH_FRONT;
    end else if (pos < active + fp + sync) begin
      return PH_SYNC;
    end else begin
      return PH_BACK;
    end
  endfunction

endpackage

// File: rtl/plot_framebuffer_scan_if.sv
// Pixel plot write bus: one coordinate/colour write per cycle while iPlot is high.
// The producer drives the master modport, the framebuffer listens on slave.
interface plot_framebuffer_scan_if;
  import plot_fb_pkg::*;

  logic [7:0] iX;
  logic [6:0] iY;
  colour_t    iColour;
  logic       iPlot;

  modport master (output iX, iY, iColour, iPlot);
  modport slave  (input  iX, iY, iColour, iPlot);

endinterface

// File: rtl/plot_fb_ram.sv
// Simple dual-port pixel memory: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old data.
module plot_fb_ram
  import plot_fb_pkg::*;
#(
  parameter int DEPTH = SCREEN_W * SCREEN_H
) (
  input  logic    clk_i,
  input  logic    wrEn_i,
  input  addr_t   wrAddr_i,
  input  colour_t wrData_i,
  input  logic    rdEn_i,
  input  addr_t   rdAddr_i,
  output colour_t rdData_o
);

  colour_t mem [DEPTH];
  colour_t rdData_q;

  // No reset on purpose: contents survive reset and the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
    if (rdEn_i) begin
      rdData_q <= mem[rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/plot_framebuffer_scan.sv
// Plot-addressable framebuffer with a raster scanner producing colour, syncs and blank.
// Defining PLOT_DROP_COUNT_EN adds oDropCount, a saturating count of out-of-range plots.
module plot_framebuffer_scan
  import plot_fb_pkg::*;
#(
  parameter int H_ACTIVE = SCREEN_W,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 24,
  parameter int H_BP     = 12,
  parameter int V_ACTIVE = SCREEN_H,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 8,
  parameter int PIX_DIV  = 1
) (
  input  logic                    iClock,
  input  logic                    iReset,
  plot_framebuffer_scan_if.slave  plotIf,
  output colour_t                 oColour,
  output logic                    oHS,
  output logic                    oVS,
  output logic                    oBlank,
  output logic                    oFrameStart
`ifdef PLOT_DROP_COUNT_EN
  ,
  output logic [15:0]             oDropCount
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [HC_W-1:0]  hCnt_q, hCnt_d;
  logic [VC_W-1:0]  vCnt_q, vCnt_d;
  logic             pixTick;

  phase_t    hPhase, vPhase;
  logic      visible;
  addr_t     rdAddr;
  colour_t   rdData;

  logic      inRange;
  logic      wrEn;
  addr_t     wrAddr;

  syncBits_t stage1_q, stage1_d;
  syncBits_t stage2_q;
  colour_t   colour_q, colour_d;

  // Write side: reject off-screen coordinates and anything plotted while in reset.
  always_comb begin
    inRange = (32'(plotIf.iX) < H_ACTIVE) && (32'(plotIf.iY) < V_ACTIVE);
    wrEn    = plotIf.iPlot && inRange && !iReset;
    wrAddr  = ADDR_W'(plotIf.iY) * ADDR_W'(H_ACTIVE) + ADDR_W'(plotIf.iX);
  end

  // Scan counters only move on the last cycle of each pixel period.
  always_comb begin
    pixTick  = (32'(divCnt_q) == PIX_DIV - 1);
    divCnt_d = pixTick ? '0 : divCnt_q + 1'b1;
    hCnt_d   = hCnt_q;
    vCnt_d   = vCnt_q;
    if (pixTick) begin
      if (32'(hCnt_q) == H_TOTAL - 1) begin
        hCnt_d = '0;
        vCnt_d = (32'(vCnt_q) == V_TOTAL - 1) ? '0 : vCnt_q + 1'b1;
      end else begin
        hCnt_d = hCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      divCnt_q <= '0;
      hCnt_q   <= '0;
      vCnt_q   <= '0;
    end else begin
      divCnt_q <= divCnt_d;
      hCnt_q   <= hCnt_d;
      vCnt_q   <= vCnt_d;
    end
  end

  always_comb begin
    hPhase  = phaseOf(int'(hCnt_q), H_ACTIVE, H_FP, H_SYNC);
    vPhase  = phaseOf(int'(vCnt_q), V_ACTIVE, V_FP, V_SYNC);
    visible = (hPhase == PH_ACTIVE) && (vPhase == PH_ACTIVE);
    rdAddr  = visible ? (ADDR_W'(vCnt_q) * ADDR_W'(H_ACTIVE) + ADDR_W'(hCnt_q)) : '0;
  end

  plot_fb_ram #(
    .DEPTH (H_ACTIVE * V_ACTIVE)
  ) uRam (
    .clk_i    (iClock),
    .wrEn_i   (wrEn),
    .wrAddr_i (wrAddr),
    .wrData_i (plotIf.iColour),
    .rdEn_i   (visible),
    .rdAddr_i (rdAddr),
    .rdData_o (rdData)
  );

  // Timing bits take one stage to line up with the RAM read, then a second stage
  // joins them with the pixel so every output trails the counters by two cycles.
  always_comb begin
    stage1_d.hs         = (hPhase != PH_SYNC);
    stage1_d.vs         = (vPhase != PH_SYNC);
    stage1_d.blank      = !visible;
    stage1_d.frameStart = (hCnt_q == '0) && (vCnt_q == '0) && (divCnt_q == '0);
    colour_d            = stage1_q.blank ? '0 : rdData;
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      stage1_q <= SYNC_IDLE;
      stage2_q <= SYNC_IDLE;
      colour_q <= '0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage1_q;
      colour_q <= colour_d;
    end
  end

  assign oColour     = colour_q;
  assign oHS         = stage2_q.hs;
  assign oVS         = stage2_q.vs;
  assign oBlank      = stage2_q.blank;
  assign oFrameStart = stage2_q.frameStart;

`ifdef PLOT_DROP_COUNT_EN
  logic [15:0] dropCnt_q, dropCnt_d;

  always_comb begin
    dropCnt_d = dropCnt_q;
    if (plotIf.iPlot && !inRange && (dropCnt_q != 16'hFFFF)) begin
      dropCnt_d = dropCnt_q + 1'b1;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      dropCnt_q <= '0;
    end else begin
      dropCnt_q <= dropCnt_d;
    end
  end

  assign oDropCount = dropCnt_q;
`endif

endmodule

// File: tb/tb_plot_framebuffer_scan.sv
// Directed bench for plot_framebuffer_scan: default geometry at PIX_DIV 1 and 4.
// Build with PLOT_DROP_COUNT_EN defined to also check oDropCount.
module tb_plot_framebuffer_scan;
  import plot_fb_pkg::*;

  logic    iClock = 1'b0;
  logic    iReset = 1'b1;
  colour_t oColour, oColour4;
  logic    oHS, oVS, oBlank, oFrameStart;
  logic    oHS4, oVS4, oBlank4, oFrameStart4;
`ifdef PLOT_DROP_COUNT_EN
  logic [15:0] oDropCount, oDropCount4;
`endif

  int nCompared   = 0;
  int nMismatched = 0;
  int edgeCnt     = 0;

  plot_framebuffer_scan_if plotIf ();
  plot_framebuffer_scan_if plotIf4 ();

  plot_framebuffer_scan dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .plotIf      (plotIf.slave),
    .oColour     (oColour),
    .oHS         (oHS),
    .oVS         (oVS),
    .oBlank      (oBlank),
    .oFrameStart (oFrameStart)
`ifdef PLOT_DROP_COUNT_EN
    ,
    .oDropCount  (oDropCount)
`endif
  );

  plot_framebuffer_scan #(.PIX_DIV(4)) dut4 (
    .iClock      (iClock),
    .iReset      (iReset),
    .plotIf      (plotIf4.slave),
    .oColour     (oColour4),
    .oHS         (oHS4),
    .oVS         (oVS4),
    .oBlank      (oBlank4),
    .oFrameStart (oFrameStart4)
`ifdef PLOT_DROP_COUNT_EN
    ,
    .oDropCount  (oDropCount4)
`endif
  );

  always #5 iClock = ~iClock;

  // Rising edges since the last reset release; outputs at edge k describe scan index k-2.
  always @(posedge iClock or posedge iReset) begin
    if (iReset) edgeCnt <= 0;
    else        edgeCnt <= edgeCnt + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic gotoEdge(input int k);
    while (edgeCnt < k) @(negedge iClock);
  endtask

  task automatic plot(input int x, input int y, input int c);
    plotIf.iX      = 8'(x);
    plotIf.iY      = 7'(y);
    plotIf.iColour = 3'(c);
    plotIf.iPlot   = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge iClock);
    nCompared++; if (oHS !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_hs: got %b expected 1", oHS); end
    nCompared++; if (oVS !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_vs: got %b expected 1", oVS); end
    nCompared++; if (oBlank !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_blank: got %b expected 1", oBlank); end
    nCompared++; if (oColour !== 3'd0) begin nMismatched++; $display("[TB] FAIL reset_colour: got %0d expected 0", oColour); end
    nCompared++; if (oFrameStart !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_fs: got %b expected 0", oFrameStart); end
    nCompared++; if (oHS4 !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_hs_div4: got %b expected 1", oHS4); end
    iReset = 1'b0;
  endtask

  task automatic test_writes;
    gotoEdge(0);
    plot(2, 0, 1);
    plotIf4.iX = 8'd3; plotIf4.iY = 7'd0; plotIf4.iColour = 3'd6; plotIf4.iPlot = 1'b1;
    gotoEdge(1);
    plot(5, 7, 5);
    plotIf4.iX = 8'd4; plotIf4.iColour = 3'd1;
    gotoEdge(2);
    plot(0, 1, 3);
    plotIf4.iPlot = 1'b0;
    gotoEdge(3);
    plot(6, 7, 2);
    gotoEdge(4);
    plot(160, 0, 7);
    gotoEdge(5);
    plot(0, 120, 7);
    gotoEdge(6);
    plotIf.iPlot = 1'b0;
    gotoEdge(10);
    plot(0, 0, 0);
    gotoEdge(11);
    plotIf.iPlot = 1'b0;
  endtask

  task automatic test_pix_div4;
    for (int k = 14; k <= 17; k++) begin
      gotoEdge(k);
      nCompared++; if (oColour4 !== 3'd6) begin nMismatched++; $display("[TB] FAIL div4_hold_px3 edge %0d: got %0d expected 6", k, oColour4); end
    end
    gotoEdge(18);
    nCompared++; if (oColour4 !== 3'd1) begin nMismatched++; $display("[TB] FAIL div4_px4: got %0d expected 1", oColour4); end
    nCompared++; if (oBlank4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL div4_blank: got %b expected 0", oBlank4); end
    gotoEdge(657);
    nCompared++; if (oHS4 !== 1'b1) begin nMismatched++; $display("[TB] FAIL div4_hs_pre: got %b expected 1", oHS4); end
    gotoEdge(658);
    nCompared++; if (oHS4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL div4_hs_start: got %b expected 0", oHS4); end
    gotoEdge(1457);
    nCompared++; if (oHS4 !== 1'b1) begin nMismatched++; $display("[TB] FAIL div4_hs_pre_line1: got %b expected 1", oHS4); end
    gotoEdge(1458);
    nCompared++; if (oHS4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL div4_hs_start_line1: got %b expected 0", oHS4); end
  endtask

  task automatic test_collision_old;
    gotoEdge(26600);
    plot(0, 0, 2);
    gotoEdge(26601);
    plotIf.iPlot = 1'b0;
    nCompared++; if (oFrameStart !== 1'b0) begin nMismatched++; $display("[TB] FAIL fs_before: got %b expected 0", oFrameStart); end
    gotoEdge(26602);
    nCompared++; if (oFrameStart !== 1'b1) begin nMismatched++; $display("[TB] FAIL fs_pulse: got %b expected 1", oFrameStart); end
    nCompared++; if (oColour !== 3'd0) begin nMismatched++; $display("[TB] FAIL collision_old: got %0d expected 0", oColour); end
    nCompared++; if (oBlank !== 1'b0) begin nMismatched++; $display("[TB] FAIL origin_blank: got %b expected 0", oBlank); end
    gotoEdge(26603);
    nCompared++; if (oFrameStart !== 1'b0) begin nMismatched++; $display("[TB] FAIL fs_after: got %b expected 0", oFrameStart); end
  endtask

  task automatic test_plot;
    gotoEdge(26604);
    nCompared++; if (oColour !== 3'd1) begin nMismatched++; $display("[TB] FAIL px_2_0: got %0d expected 1", oColour); end
    gotoEdge(26802);
    nCompared++; if (oColour !== 3'd3) begin nMismatched++; $display("[TB] FAIL drop_no_alias_0_1: got %0d expected 3", oColour); end
    gotoEdge(28007);
    nCompared++; if (oColour !== 3'd5) begin nMismatched++; $display("[TB] FAIL px_5_7: got %0d expected 5", oColour); end
    nCompared++; if (oBlank !== 1'b0) begin nMismatched++; $display("[TB] FAIL px_5_7_blank: got %b expected 0", oBlank); end
    gotoEdge(28008);
    nCompared++; if (oColour !== 3'd2) begin nMismatched++; $display("[TB] FAIL px_6_7: got %0d expected 2", oColour); end
    gotoEdge(28162);
    nCompared++; if (oBlank !== 1'b1) begin nMismatched++; $display("[TB] FAIL hblank_160_7: got %b expected 1", oBlank); end
    nCompared++; if (oColour !== 3'd0) begin nMismatched++; $display("[TB] FAIL hblank_colour: got %0d expected 0", oColour); end
  endtask

  task automatic test_hsync;
    int lowCnt = 0;
    int fsCnt  = 0;
    for (int i = 0; i < 200; i++) begin
      gotoEdge(28602 + i);
      if (oHS === 1'b0) lowCnt++;
      if (oFrameStart === 1'b1) fsCnt++;
      if (i == 163) begin nCompared++; if (oHS !== 1'b1) begin nMismatched++; $display("[TB] FAIL hs_x163: got %b expected 1", oHS); end end
      if (i == 164) begin nCompared++; if (oHS !== 1'b0) begin nMismatched++; $display("[TB] FAIL hs_x164: got %b expected 0", oHS); end end
      if (i == 187) begin nCompared++; if (oHS !== 1'b0) begin nMismatched++; $display("[TB] FAIL hs_x187: got %b expected 0", oHS); end end
      if (i == 188) begin nCompared++; if (oHS !== 1'b1) begin nMismatched++; $display("[TB] FAIL hs_x188: got %b expected 1", oHS); end end
    end
    nCompared++; if (lowCnt !== 24) begin nMismatched++; $display("[TB] FAIL hs_low_count: got %0d expected 24", lowCnt); end
    nCompared++; if (fsCnt !== 0) begin nMismatched++; $display("[TB] FAIL fs_midframe_count: got %0d expected 0", fsCnt); end
  endtask

  task automatic test_vsync;
    int lowCnt = 0;
    for (int i = 0; i < 1000; i++) begin
      gotoEdge(51002 + i);
      if (oVS === 1'b0) lowCnt++;
      if (i == 0) begin nCompared++; if (oBlank !== 1'b1) begin nMismatched++; $display("[TB] FAIL vblank_line122: got %b expected 1", oBlank); end end
      if (i == 199) begin nCompared++; if (oVS !== 1'b1) begin nMismatched++; $display("[TB] FAIL vs_line122_end: got %b expected 1", oVS); end end
      if (i == 200) begin nCompared++; if (oVS !== 1'b0) begin nMismatched++; $display("[TB] FAIL vs_line123_start: got %b expected 0", oVS); end end
      if (i == 599) begin nCompared++; if (oVS !== 1'b0) begin nMismatched++; $display("[TB] FAIL vs_line124_end: got %b expected 0", oVS); end end
      if (i == 600) begin nCompared++; if (oVS !== 1'b1) begin nMismatched++; $display("[TB] FAIL vs_line125_start: got %b expected 1", oVS); end end
    end
    nCompared++; if (lowCnt !== 400) begin nMismatched++; $display("[TB] FAIL vs_low_count: got %0d expected 400", lowCnt); end
  endtask

  task automatic test_collision_new;
    gotoEdge(53202);
    nCompared++; if (oFrameStart !== 1'b1) begin nMismatched++; $display("[TB] FAIL fs_frame2: got %b expected 1", oFrameStart); end
    nCompared++; if (oColour !== 3'd2) begin nMismatched++; $display("[TB] FAIL collision_new: got %0d expected 2", oColour); end
  endtask

  task automatic test_drop_count;
`ifdef PLOT_DROP_COUNT_EN
    nCompared++; if (oDropCount !== 16'd2) begin nMismatched++; $display("[TB] FAIL drop_count: got %0d expected 2", oDropCount); end
    nCompared++; if (oDropCount4 !== 16'd0) begin nMismatched++; $display("[TB] FAIL drop_count_div4: got %0d expected 0", oDropCount4); end
`endif
  endtask

  task automatic test_mid_reset;
    gotoEdge(65250);
    iReset = 1'b1;
    plot(2, 0, 6);
    #1;
    nCompared++; if (oBlank !== 1'b1) begin nMismatched++; $display("[TB] FAIL midrst_blank: got %b expected 1", oBlank); end
    nCompared++; if (oColour !== 3'd0) begin nMismatched++; $display("[TB] FAIL midrst_colour: got %0d expected 0", oColour); end
    repeat (3) @(negedge iClock);
    nCompared++; if (oHS !== 1'b1) begin nMismatched++; $display("[TB] FAIL midrst_hs: got %b expected 1", oHS); end
    nCompared++; if (oVS !== 1'b1) begin nMismatched++; $display("[TB] FAIL midrst_vs: got %b expected 1", oVS); end
    nCompared++; if (oFrameStart !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_fs: got %b expected 0", oFrameStart); end
`ifdef PLOT_DROP_COUNT_EN
    nCompared++; if (oDropCount !== 16'd0) begin nMismatched++; $display("[TB] FAIL midrst_dropcount: got %0d expected 0", oDropCount); end
`endif
    plotIf.iPlot = 1'b0;
    iReset = 1'b0;
    gotoEdge(1);
    nCompared++; if (oFrameStart !== 1'b0) begin nMismatched++; $display("[TB] FAIL release_fs_early: got %b expected 0", oFrameStart); end
    gotoEdge(2);
    nCompared++; if (oFrameStart !== 1'b1) begin nMismatched++; $display("[TB] FAIL release_fs: got %b expected 1", oFrameStart); end
    nCompared++; if (oColour !== 3'd2) begin nMismatched++; $display("[TB] FAIL release_retained_0_0: got %0d expected 2", oColour); end
    gotoEdge(4);
    nCompared++; if (oColour !== 3'd1) begin nMismatched++; $display("[TB] FAIL reset_write_ignored: got %0d expected 1", oColour); end
  endtask

  initial begin
    plotIf.iX = '0;  plotIf.iY = '0;  plotIf.iColour = '0;  plotIf.iPlot = 1'b0;
    plotIf4.iX = '0; plotIf4.iY = '0; plotIf4.iColour = '0; plotIf4.iPlot = 1'b0;
    test_reset();
    test_writes();
    test_pix_div4();
    test_collision_old();
    test_plot();
    test_hsync();
    test_vsync();
    test_collision_new();
    test_drop_count();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
